// File: rtl/cart_sdram_arbiter.sv
// Cartridge SDRAM arbiter: shares one single-outstanding SDRAM port between a ROM loader
// (write-only, highest priority) and two round-robin slots A and B.
// Optional feature macro: CART_ARB_LOADER_EN (loader port arbitrated when defined; otherwise
// ld_* inputs are ignored and ld_ack is tied low).
module cart_sdram_arbiter #(
  parameter int unsigned ADDR_W  = 25,
  parameter int unsigned TIMEOUT = 15
) (
  input  logic              clk,
  input  logic              reset,
  // Loader
  input  logic              ld_req,
  output logic              ld_ack,
  input  logic [ADDR_W-1:0] ld_addr,
  input  logic [7:0]        ld_data,
  // Slot A
  input  logic              a_req,
  input  logic              a_we,
  input  logic [ADDR_W-1:0] a_addr,
  input  logic [7:0]        a_wdata,
  output logic [7:0]        a_rdata,
  output logic              a_ack,
  // Slot B
  input  logic              b_req,
  input  logic              b_we,
  input  logic [ADDR_W-1:0] b_addr,
  input  logic [7:0]        b_wdata,
  output logic [7:0]        b_rdata,
  output logic              b_ack,
  // Memory side
  output logic              sd_req,
  output logic              sd_we,
  output logic [ADDR_W-1:0] sd_addr,
  output logic [7:0]        sd_wdata,
  input  logic [7:0]        sd_rdata,
  input  logic              sd_ready,
  output logic              busy
);

  localparam int unsigned CntW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  // Last WAIT cycle index; sd_ready in this cycle still wins over the abort.
  localparam logic [CntW-1:0] CntLast = CntW'(TIMEOUT - 1);

  typedef enum logic [1:0] {StIdle, StIssue, StWait, StDone} state_t;
  typedef enum logic [1:0] {GntLd, GntA, GntB} gnt_t;

  state_t            state_q;
  gnt_t              gnt_q;
  logic              last_b_q;    // 1: slot B was granted last, so A wins the next tie
  logic [CntW-1:0]   wait_cnt_q;
  logic              ld_ack_q;

  logic              ld_pending;
  logic              grant_valid;
  gnt_t              grant_sel;
  logic [ADDR_W-1:0] grant_addr;
  logic              grant_we;
  logic [7:0]        grant_wdata;
  logic [7:0]        rd_value;

`ifdef CART_ARB_LOADER_EN
  assign ld_pending = ld_req;
  assign ld_ack     = ld_ack_q;
`else
  logic unused_ld;
  assign ld_pending = 1'b0;
  assign ld_ack     = 1'b0;
  assign unused_ld  = ^{ld_req, ld_ack_q};
`endif

  assign busy = (state_q != StIdle);

  // Aborted reads return all-ones.
  assign rd_value = sd_ready ? sd_rdata : 8'hFF;

  // Pick the requester to serve next: loader first, then A/B round-robin.
  always_comb begin
    grant_valid = 1'b1;
    grant_sel   = GntA;
    if (ld_pending) begin
      grant_sel = GntLd;
    end else if (a_req && b_req) begin
      grant_sel = last_b_q ? GntA : GntB;
    end else if (a_req) begin
      grant_sel = GntA;
    end else if (b_req) begin
      grant_sel = GntB;
    end else begin
      grant_valid = 1'b0;
    end
  end

  // Select the command fields of the chosen requester; the loader always writes.
  always_comb begin
    grant_addr  = a_addr;
    grant_we    = a_we;
    grant_wdata = a_wdata;
    case (grant_sel)
      GntLd: begin
        grant_addr  = ld_addr;
        grant_we    = 1'b1;
        grant_wdata = ld_data;
      end
      GntB: begin
        grant_addr  = b_addr;
        grant_we    = b_we;
        grant_wdata = b_wdata;
      end
      default: begin
        grant_addr  = a_addr;
        grant_we    = a_we;
        grant_wdata = a_wdata;
      end
    endcase
  end

  // Transaction FSM with registered memory-side and acknowledge outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= StIdle;
      gnt_q      <= GntA;
      last_b_q   <= 1'b1;
      wait_cnt_q <= '0;
      sd_req     <= 1'b0;
      sd_we      <= 1'b0;
      sd_addr    <= '0;
      sd_wdata   <= '0;
      a_ack      <= 1'b0;
      b_ack      <= 1'b0;
      ld_ack_q   <= 1'b0;
      a_rdata    <= 8'hFF;
      b_rdata    <= 8'hFF;
    end else begin
      // Strobes and acks are single-cycle pulses.
      sd_req   <= 1'b0;
      a_ack    <= 1'b0;
      b_ack    <= 1'b0;
      ld_ack_q <= 1'b0;
      case (state_q)
        StIdle: begin
          if (grant_valid) begin
            gnt_q    <= grant_sel;
            sd_addr  <= grant_addr;
            sd_we    <= grant_we;
            sd_wdata <= grant_wdata;
            sd_req   <= 1'b1;
            state_q  <= StIssue;
            if (grant_sel == GntA) begin
              last_b_q <= 1'b0;
            end else if (grant_sel == GntB) begin
              last_b_q <= 1'b1;
            end
          end
        end
        StIssue: begin
          wait_cnt_q <= '0;
          state_q    <= StWait;
        end
        StWait: begin
          if (sd_ready || (wait_cnt_q == CntLast)) begin
            if (!sd_we) begin
              if (gnt_q == GntA) begin
                a_rdata <= rd_value;
              end else if (gnt_q == GntB) begin
                b_rdata <= rd_value;
              end
            end
            a_ack    <= (gnt_q == GntA);
            b_ack    <= (gnt_q == GntB);
            ld_ack_q <= (gnt_q == GntLd);
            state_q  <= StDone;
          end else begin
            wait_cnt_q <= wait_cnt_q + CntW'(1);
          end
        end
        StDone: begin
          // Command fields return to zero so an idle bus is all-zero.
          sd_we    <= 1'b0;
          sd_addr  <= '0;
          sd_wdata <= '0;
          state_q  <= StIdle;
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cart_sdram_arbiter.sv
// Self-checking bench for cart_sdram_arbiter: expected transactions are queued when requests
// are driven and popped when the arbiter issues them; a small memory responder per transaction
// drives sd_ready after a chosen delay.
module tb_cart_sdram_arbiter;

  localparam int ADDR_W  = 25;
  localparam int TIMEOUT = 15;

  logic              clk = 1'b0;
  logic              reset;
  logic              ld_req, ld_ack;
  logic [ADDR_W-1:0] ld_addr;
  logic [7:0]        ld_data;
  logic              a_req, a_we, a_ack;
  logic [ADDR_W-1:0] a_addr;
  logic [7:0]        a_wdata, a_rdata;
  logic              b_req, b_we, b_ack;
  logic [ADDR_W-1:0] b_addr;
  logic [7:0]        b_wdata, b_rdata;
  logic              sd_req, sd_we, sd_ready, busy;
  logic [ADDR_W-1:0] sd_addr;
  logic [7:0]        sd_wdata, sd_rdata;

  typedef struct {
    int                slot;   // 0 loader, 1 A, 2 B
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [7:0]        wdata;
  } exp_t;

  exp_t       q[$];
  int         tests = 0;
  int         fails = 0;
  logic [7:0] model_a, model_b;
  int         issue_wait;

  cart_sdram_arbiter #(
    .ADDR_W  (ADDR_W),
    .TIMEOUT (TIMEOUT)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .ld_req   (ld_req),
    .ld_ack   (ld_ack),
    .ld_addr  (ld_addr),
    .ld_data  (ld_data),
    .a_req    (a_req),
    .a_we     (a_we),
    .a_addr   (a_addr),
    .a_wdata  (a_wdata),
    .a_rdata  (a_rdata),
    .a_ack    (a_ack),
    .b_req    (b_req),
    .b_we     (b_we),
    .b_addr   (b_addr),
    .b_wdata  (b_wdata),
    .b_rdata  (b_rdata),
    .b_ack    (b_ack),
    .sd_req   (sd_req),
    .sd_we    (sd_we),
    .sd_addr  (sd_addr),
    .sd_wdata (sd_wdata),
    .sd_rdata (sd_rdata),
    .sd_ready (sd_ready),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  task automatic push(input int slot, input logic we, input logic [ADDR_W-1:0] addr,
                      input logic [7:0] wdata);
    exp_t e;
    e.slot  = slot;
    e.we    = we;
    e.addr  = addr;
    e.wdata = wdata;
    q.push_back(e);
  endtask

  task automatic do_reset();
    reset    = 1'b1;
    ld_req   = 1'b0; ld_addr = '0; ld_data = '0;
    a_req    = 1'b0; a_we    = 1'b0; a_addr = '0; a_wdata = '0;
    b_req    = 1'b0; b_we    = 1'b0; b_addr = '0; b_wdata = '0;
    sd_ready = 1'b0; sd_rdata = '0;
    q.delete();
    @(negedge clk);
    @(negedge clk);
    reset   = 1'b0;
    model_a = 8'hFF;
    model_b = 8'hFF;
  endtask

  // Serve one transaction: check the issue, respond after 'delay' WAIT cycles (negative or
  // >= TIMEOUT means never), then check ack, latency and read-data registers.
  task automatic serve(input int delay, input logic [7:0] rd, input bit hold, input bit glitch);
    exp_t       e;
    int         n;
    int         lat;
    int         exp_lat;
    bit         got;
    bit         bad;
    bit         success;
    logic [2:0] exp_ack;
    n = 0;
    while (sd_req !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    issue_wait = n;
    tests++;
    if (sd_req !== 1'b1) begin
      fails++;
      $display("FAIL issue: sd_req=%b after %0d cycles, required 1", sd_req, n);
      return;
    end
    if (q.size() == 0) begin
      fails++;
      $display("FAIL scoreboard: unexpected transaction addr=%h, required none", sd_addr);
      return;
    end
    e = q.pop_front();
    tests++;
    if (sd_we !== e.we || sd_addr !== e.addr || sd_wdata !== e.wdata) begin
      fails++;
      $display("FAIL issue_fields: we=%b addr=%h wdata=%h, required we=%b addr=%h wdata=%h",
               sd_we, sd_addr, sd_wdata, e.we, e.addr, e.wdata);
    end
    // A ready during ISSUE must be ignored.
    if (glitch) begin
      sd_ready = 1'b1;
      sd_rdata = 8'hEE;
    end
    @(negedge clk);
    lat = 1;
    got = 1'b0;
    bad = 1'b0;
    if (glitch) begin
      a_addr  = ~a_addr;
      a_wdata = ~a_wdata;
      a_we    = ~a_we;
      b_req   = 1'b1;
    end
    for (int k = 0; k < 3 * TIMEOUT && !got; k++) begin
      sd_ready = (k == delay);
      sd_rdata = (k == delay) ? rd : 8'hC3;
      if (sd_req !== 1'b0 || busy !== 1'b1 || sd_we !== e.we || sd_addr !== e.addr ||
          sd_wdata !== e.wdata || {ld_ack, a_ack, b_ack} !== 3'b000) bad = 1'b1;
      @(negedge clk);
      lat++;
      if ({ld_ack, a_ack, b_ack} !== 3'b000) got = 1'b1;
    end
    sd_ready = 1'b0;
    sd_rdata = 8'h00;
    if (sd_we !== e.we || sd_addr !== e.addr || sd_wdata !== e.wdata || busy !== 1'b1) bad = 1'b1;
    tests++;
    if (bad) begin
      fails++;
      $display("FAIL wait_stable: command/busy/ack changed before DONE, required stable");
    end
    exp_ack = (e.slot == 0) ? 3'b100 : (e.slot == 1) ? 3'b010 : 3'b001;
    tests++;
    if ({ld_ack, a_ack, b_ack} !== exp_ack) begin
      fails++;
      $display("FAIL ack_slot: {ld,a,b}_ack=%b, required %b", {ld_ack, a_ack, b_ack}, exp_ack);
    end
    success = (delay >= 0) && (delay < TIMEOUT);
    exp_lat = success ? delay + 2 : TIMEOUT + 1;
    tests++;
    if (lat !== exp_lat) begin
      fails++;
      $display("FAIL ack_latency: %0d cycles after issue, required %0d", lat, exp_lat);
    end
    if (!e.we) begin
      if (e.slot == 1) model_a = success ? rd : 8'hFF;
      if (e.slot == 2) model_b = success ? rd : 8'hFF;
    end
    tests++;
    if (a_rdata !== model_a || b_rdata !== model_b) begin
      fails++;
      $display("FAIL rdata: a=%h b=%h, required a=%h b=%h", a_rdata, b_rdata, model_a, model_b);
    end
    if (!hold) begin
      if (e.slot == 0) ld_req = 1'b0;
      if (e.slot == 1) a_req = 1'b0;
      if (e.slot == 2) b_req = 1'b0;
    end
    @(negedge clk);
    tests++;
    if ({ld_ack, a_ack, b_ack} !== 3'b000 || busy !== 1'b0) begin
      fails++;
      $display("FAIL ack_pulse: acks=%b busy=%b after DONE, required 000 and 0",
               {ld_ack, a_ack, b_ack}, busy);
    end
  endtask

  task automatic test_reset();
    do_reset();
    tests++;
    if (busy !== 1'b0 || sd_req !== 1'b0 || sd_we !== 1'b0) begin
      fails++;
      $display("FAIL reset_ctrl: busy=%b sd_req=%b sd_we=%b, required 0 0 0", busy, sd_req, sd_we);
    end
    tests++;
    if (sd_addr !== '0 || sd_wdata !== 8'h00) begin
      fails++;
      $display("FAIL reset_bus: sd_addr=%h sd_wdata=%h, required 0 0", sd_addr, sd_wdata);
    end
    tests++;
    if ({ld_ack, a_ack, b_ack} !== 3'b000) begin
      fails++;
      $display("FAIL reset_ack: acks=%b, required 000", {ld_ack, a_ack, b_ack});
    end
    tests++;
    if (a_rdata !== 8'hFF || b_rdata !== 8'hFF) begin
      fails++;
      $display("FAIL reset_rdata: a=%h b=%h, required FF FF", a_rdata, b_rdata);
    end
  endtask

  task automatic test_basic_read();
    @(negedge clk);
    a_req = 1'b1; a_we = 1'b0; a_addr = 25'h0004000; a_wdata = 8'h00;
    push(1, 1'b0, 25'h0004000, 8'h00);
    serve(0, 8'h5A, 1'b0, 1'b0);
    tests++;
    if (issue_wait !== 1) begin
      fails++;
      $display("FAIL req_to_issue: %0d cycles, required 1", issue_wait);
    end
    tests++;
    if (a_rdata !== 8'h5A) begin
      fails++;
      $display("FAIL basic_rdata: a_rdata=%h, required 5A", a_rdata);
    end
  endtask

  task automatic test_round_robin();
    do_reset();
    a_req = 1'b1; a_we = 1'b0; a_addr = 25'h0000100; a_wdata = 8'h00;
    b_req = 1'b1; b_we = 1'b0; b_addr = 25'h0000200; b_wdata = 8'h00;
    push(1, 1'b0, 25'h0000100, 8'h00);
    push(2, 1'b0, 25'h0000200, 8'h00);
    push(1, 1'b0, 25'h0000100, 8'h00);
    push(2, 1'b0, 25'h0000200, 8'h00);
    serve(1, 8'h11, 1'b1, 1'b0);
    serve(0, 8'h22, 1'b1, 1'b0);
    serve(2, 8'h33, 1'b0, 1'b0);
    serve(0, 8'h44, 1'b0, 1'b0);
  endtask

  task automatic test_write();
    a_req = 1'b1; a_we = 1'b1; a_addr = 25'h1234567; a_wdata = 8'h77;
    push(1, 1'b1, 25'h1234567, 8'h77);
    serve(1, 8'hAB, 1'b0, 1'b0);
    a_we = 1'b0;
  endtask

  task automatic test_timeout();
    b_req = 1'b1; b_we = 1'b0; b_addr = 25'h0ABCDEF; b_wdata = 8'h00;
    push(2, 1'b0, 25'h0ABCDEF, 8'h00);
    serve(-1, 8'h00, 1'b0, 1'b0);
    tests++;
    if (b_rdata !== 8'hFF) begin
      fails++;
      $display("FAIL timeout_rdata: b_rdata=%h, required FF", b_rdata);
    end
    // Ready on the last WAIT cycle still counts as success.
    a_req = 1'b1; a_we = 1'b0; a_addr = 25'h0000321; a_wdata = 8'h00;
    push(1, 1'b0, 25'h0000321, 8'h00);
    serve(TIMEOUT - 1, 8'h81, 1'b0, 1'b0);
  endtask

  task automatic test_req_change();
    a_req = 1'b1; a_we = 1'b0; a_addr = 25'h0000AAA; a_wdata = 8'h00;
    b_we  = 1'b0; b_addr = 25'h0000BBB; b_wdata = 8'h00;
    push(1, 1'b0, 25'h0000AAA, 8'h00);
    push(2, 1'b0, 25'h0000BBB, 8'h00);
    serve(1, 8'h6B, 1'b0, 1'b1);
    serve(0, 8'h9C, 1'b0, 1'b0);
    a_we = 1'b0;
  endtask

  task automatic test_loader();
    bit seen;
    do_reset();
    ld_req = 1'b1; ld_addr = 25'h01ABCDE; ld_data = 8'h3C;
    a_req  = 1'b1; a_we = 1'b0; a_addr = 25'h0000010; a_wdata = 8'h00;
    b_req  = 1'b1; b_we = 1'b0; b_addr = 25'h0000020; b_wdata = 8'h00;
`ifdef CART_ARB_LOADER_EN
    push(0, 1'b1, 25'h01ABCDE, 8'h3C);
    push(1, 1'b0, 25'h0000010, 8'h00);
    push(2, 1'b0, 25'h0000020, 8'h00);
    serve(0, 8'h99, 1'b0, 1'b0);
    serve(1, 8'h12, 1'b0, 1'b0);
    serve(0, 8'h34, 1'b0, 1'b0);
`else
    push(1, 1'b0, 25'h0000010, 8'h00);
    push(2, 1'b0, 25'h0000020, 8'h00);
    serve(1, 8'h12, 1'b0, 1'b0);
    serve(0, 8'h34, 1'b0, 1'b0);
    seen = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (ld_ack !== 1'b0 || busy !== 1'b0) seen = 1'b1;
    end
    tests++;
    if (seen) begin
      fails++;
      $display("FAIL loader_ignored: ld_ack/busy asserted with loader disabled, required 0");
    end
    ld_req = 1'b0;
`endif
  endtask

  task automatic test_reset_mid_wait();
    int n;
    bit seen;
    @(negedge clk);
    a_req = 1'b1; a_we = 1'b0; a_addr = 25'h0000077; a_wdata = 8'h00;
    n = 0;
    while (sd_req !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    @(negedge clk);
    @(negedge clk);
    tests++;
    if (busy !== 1'b1) begin
      fails++;
      $display("FAIL mid_wait_busy: busy=%b, required 1", busy);
    end
    reset = 1'b1;
    a_req = 1'b0;
    @(negedge clk);
    tests++;
    if (busy !== 1'b0 || sd_req !== 1'b0 || {ld_ack, a_ack, b_ack} !== 3'b000 ||
        a_rdata !== 8'hFF || b_rdata !== 8'hFF) begin
      fails++;
      $display("FAIL mid_reset: busy=%b sd_req=%b acks=%b a=%h b=%h, required 0 0 000 FF FF",
               busy, sd_req, {ld_ack, a_ack, b_ack}, a_rdata, b_rdata);
    end
    reset   = 1'b0;
    model_a = 8'hFF;
    model_b = 8'hFF;
    seen    = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if ({ld_ack, a_ack, b_ack} !== 3'b000) seen = 1'b1;
    end
    tests++;
    if (seen) begin
      fails++;
      $display("FAIL mid_reset_ack: ack seen after abandoned transaction, required none");
    end
    a_req = 1'b1; a_we = 1'b0; a_addr = 25'h0000078; a_wdata = 8'h00;
    push(1, 1'b0, 25'h0000078, 8'h00);
    serve(2, 8'hD4, 1'b0, 1'b0);
  endtask

  initial begin
    test_reset();
    test_basic_read();
    test_round_robin();
    test_write();
    test_timeout();
    test_req_change();
    test_loader();
    test_reset_mid_wait();
    tests++;
    if (q.size() != 0) begin
      fails++;
      $display("FAIL scoreboard_drain: %0d transactions left, required 0", q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/cart_sdram_arbiter.md
CART_SDRAM_ARBITER -- requirements
Module: cart_sdram_arbiter

Interface
REQ-001 The block SHALL have parameter ADDR_W, default 25, giving the memory address width.
REQ-002 The block SHALL have parameter TIMEOUT, default 15, giving the WAIT cycles before a transaction is aborted.
REQ-003 The block SHALL have port clk, input, 1, the system clock.
REQ-004 The block SHALL have port reset, input, 1: synchronous, active-high reset.
REQ-005 The block SHALL have port ld_req / ld_ack, input / output, 1 / 1: loader write request / one-cycle acknowledge.
REQ-006 The block SHALL have port ld_addr / ld_data, input, ADDR_W / 8: loader address and write data.
REQ-007 The block SHALL have port a_req, a_we, input, 1 each: slot A request and write-enable.
REQ-008 The block SHALL have port a_addr / a_wdata, input, ADDR_W / 8: slot A address and write data.
REQ-009 The block SHALL have port a_rdata / a_ack, output, 8 / 1: slot A read data and one-cycle acknowledge.
REQ-010 The block SHALL have port b_req, b_we, b_addr, b_wdata, b_rdata, b_ack, with widths identical to slot A, for slot B.
REQ-011 The block SHALL have port sd_req, sd_we, output, 1 each: memory strobe and write-enable.
REQ-012 The block SHALL have port sd_addr / sd_wdata, output, ADDR_W / 8: memory address and write data.
REQ-013 The block SHALL have port sd_rdata / sd_ready, input, 8 / 1: memory read data and completion.
REQ-014 The block SHALL have port busy, output, 1, high whenever the FSM is not IDLE.

Function
REQ-015 FSM states SHALL be IDLE, ISSUE, WAIT, DONE; exactly one transaction SHALL be outstanding.
REQ-016 In IDLE, the arbiter SHALL grant ld_req first; otherwise it SHALL grant a_req/b_req round-robin using last_grant (both pending -> the slot not granted last).
REQ-017 On grant, the arbiter SHALL latch addr, we (loader: always 1), and wdata, then move to ISSUE.
REQ-018 With no request in IDLE, the FSM SHALL stay in IDLE with all outputs 0.
REQ-019 ISSUE SHALL last exactly one cycle: sd_req=1 with latched sd_addr/sd_we/sd_wdata, then WAIT.
REQ-020 sd_addr/sd_we/sd_wdata SHALL stay stable from ISSUE until DONE.
REQ-021 sd_ready SHALL be ignored outside WAIT.
REQ-022 In WAIT, sd_ready=1 SHALL capture sd_rdata into the read-data register of the granted slot and move to DONE.
REQ-023 The WAIT counter SHALL reset on WAIT entry; after TIMEOUT cycles without sd_ready, the arbiter SHALL abort to DONE, and a read SHALL return 8'hFF.
REQ-024 sd_ready arriving in the same cycle the counter reaches TIMEOUT SHALL count as success.
REQ-025 DONE SHALL pulse the granted requester's ack for one cycle, then move to IDLE.
REQ-026 a_rdata/b_rdata SHALL hold their value until that slot's next read completes; writes SHALL leave them unchanged.
REQ-027 Requesters hold req until ack and drop it the next cycle; IDLE SHALL therefore always re-sample fresh requests.
REQ-028 Minimum latency SHALL be req in cycle 0 -> sd_req in cycle 1 -> ready in cycle 2 -> ack in cycle 3.
REQ-029 A req change while not in IDLE SHALL have no effect on the current transaction.

Reset
REQ-030 Reset SHALL force IDLE; sd_req, sd_we, all acks, and busy SHALL be 0; sd_addr/sd_wdata 0; a_rdata/b_rdata 8'hFF; last_grant = B, so A wins the first tie.
REQ-031 Reset mid-transaction SHALL abandon the transaction without asserting any ack.

Configuration
REQ-032 With CART_ARB_LOADER_EN defined, the loader port SHALL be arbitrated per REQ-016.
REQ-033 Without CART_ARB_LOADER_EN, ld_* inputs SHALL be ignored and ld_ack SHALL be tied 0; only A/B round-robin remains.

Verification
REQ-034 Bench: a_req read 0x0004000, sd_ready in cycle 2, sd_rdata=0x5A -> a_ack in cycle 3, a_rdata=0x5A.
REQ-035 Bench: a_req and b_req simultaneous after reset, held -> grant order A, B, A, B; each ack 1 cycle.
REQ-036 Bench: ld_req with a_req and b_req pending (LOADER_EN) -> loader write ld_data=0x3C to ld_addr first, sd_we=1.
REQ-037 Bench: b read with no sd_ready -> b_ack after 15 WAIT cycles, b_rdata=0xFF.
REQ-038 Bench: reset asserted in WAIT -> no ack, busy=0 next cycle, next a_req served normally.
REQ-039 Bench: macro undefined, ld_req=1 continuously -> ld_ack stays 0, slot traffic unaffected.
